// File: rtl/ar_uid_pkg.sv
// Shared types for the AR UID allocator: table entry layout, FSM states,
// and the index-width helper used to size encoders and counters.
package ar_uid_pkg;

    // Entry fields are sized for the widest supported ARID and counter.
    // Narrower instances leave the upper bits constant zero.
    localparam int AR_ID_MAX_W  = 16;
    localparam int AR_CNT_MAX_W = 16;

    typedef struct packed {
        logic                    busy;
        logic [AR_ID_MAX_W-1:0]  orig_id;
        logic [AR_CNT_MAX_W-1:0] cnt;
    } entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uid_prio_enc.sv
// Lowest-set-bit priority encoder: reports whether any bit is set and the
// index of the lowest one.
module uid_prio_enc
    import ar_uid_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     vec,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan downwards so the last hit written is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ar_uid_allocator.sv
// AR ID-remapping tag allocator: maps each ARID onto a live UID (same ARID
// shares one UID), translates UIDs back for the R path and frees on RLAST.
module ar_uid_allocator
    import ar_uid_pkg::*;
#(
    parameter int ID_WIDTH  = 4,
    parameter int UID_WIDTH = 8,
    parameter int NUM_UIDS  = 16,
    parameter int CNT_WIDTH = 4,
    localparam int IDX_W    = idx_width(NUM_UIDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req,
    input  logic [ID_WIDTH-1:0]  alloc_in_id,
    output logic                 alloc_gnt,
    output logic [UID_WIDTH-1:0] unique_id,
    input  logic [UID_WIDTH-1:0] lookup_uid,
    output logic [ID_WIDTH-1:0]  lookup_id,
    output logic                 lookup_hit,
    input  logic                 free_valid,
    input  logic [UID_WIDTH-1:0] free_uid,
    output logic [IDX_W:0]       busy_count,
    output logic                 full,
    output logic                 err_free
);

    localparam logic [AR_CNT_MAX_W-1:0] CNT_ONE = AR_CNT_MAX_W'(1);
    localparam logic [AR_CNT_MAX_W-1:0] CNT_MAX = AR_CNT_MAX_W'((1 << CNT_WIDTH) - 1);

    entry_t               table_reg  [NUM_UIDS];
    entry_t               table_next [NUM_UIDS];
    state_t               state_reg, state_next;
    logic [UID_WIDTH-1:0] unique_id_reg, unique_id_next;
    logic [IDX_W:0]       busy_count_reg, busy_count_next;
    logic                 full_reg, full_next;
    logic                 err_free_reg, err_free_next;

    logic [AR_ID_MAX_W-1:0] id_ext;
    logic [NUM_UIDS-1:0]    match_vec, idle_vec;
    logic                   match_found, idle_found;
    logic [IDX_W-1:0]       match_idx, idle_idx;
    logic                   commit, commit_new;
    logic [IDX_W-1:0]       sel_idx;
    logic                   free_in_range, free_ok;
    logic [IDX_W-1:0]       free_idx;
    logic                   lookup_in_range;
    logic [IDX_W-1:0]       lookup_idx;

    assign id_ext = AR_ID_MAX_W'(alloc_in_id);

    for (genvar gi = 0; gi < NUM_UIDS; gi++) begin : g_vec
        assign match_vec[gi] = table_reg[gi].busy && (table_reg[gi].orig_id == id_ext);
        assign idle_vec[gi]  = !table_reg[gi].busy;
    end

    uid_prio_enc #(.N(NUM_UIDS), .IDX_W(IDX_W)) u_match_enc (
        .vec   (match_vec),
        .found (match_found),
        .idx   (match_idx)
    );

    uid_prio_enc #(.N(NUM_UIDS), .IDX_W(IDX_W)) u_idle_enc (
        .vec   (idle_vec),
        .found (idle_found),
        .idx   (idle_idx)
    );

    assign free_in_range   = int'(free_uid) < NUM_UIDS;
    assign free_idx        = free_uid[IDX_W-1:0];
    assign free_ok         = free_valid && free_in_range && table_reg[free_idx].busy;

    assign lookup_in_range = int'(lookup_uid) < NUM_UIDS;
    assign lookup_idx      = lookup_uid[IDX_W-1:0];
    assign lookup_hit      = lookup_in_range && table_reg[lookup_idx].busy;
    assign lookup_id       = lookup_in_range ? table_reg[lookup_idx].orig_id[ID_WIDTH-1:0] : '0;

    always_comb begin
        state_next     = state_reg;
        unique_id_next = unique_id_reg;
        commit         = 1'b0;
        commit_new     = 1'b0;
        sel_idx        = match_idx;
        case (state_reg)
            IDLE: begin
                if (alloc_req) begin
                    // A live entry for this ARID blocks opening a second one,
                    // even when its counter is saturated.
                    if (match_found) begin
                        if (table_reg[match_idx].cnt != CNT_MAX) begin
                            commit  = 1'b1;
                            sel_idx = match_idx;
                        end
                    end else if (idle_found) begin
                        commit     = 1'b1;
                        commit_new = 1'b1;
                        sel_idx    = idle_idx;
                    end
                    if (commit) begin
                        state_next     = GRANT;
                        unique_id_next = UID_WIDTH'(sel_idx);
                    end
                end
            end
            GRANT: begin
                if (!alloc_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Allocation and release both act on the pre-update table; a release in
    // the same cycle as a search stays invisible to that search.
    always_comb begin
        for (int i = 0; i < NUM_UIDS; i++) begin
            logic inc, dec;
            inc = commit && (sel_idx == IDX_W'(i));
            dec = free_ok && (free_idx == IDX_W'(i));
            table_next[i] = table_reg[i];
            if (inc && commit_new) begin
                table_next[i].busy    = 1'b1;
                table_next[i].orig_id = id_ext;
                table_next[i].cnt     = CNT_ONE;
            end else if (inc && !dec) begin
                table_next[i].cnt = table_reg[i].cnt + CNT_ONE;
            end else if (dec && !inc) begin
                table_next[i].cnt = table_reg[i].cnt - CNT_ONE;
                if (table_reg[i].cnt == CNT_ONE) begin
                    table_next[i].busy = 1'b0;
                end
            end
        end
    end

    always_comb begin
        busy_count_next = '0;
        for (int i = 0; i < NUM_UIDS; i++) begin
            busy_count_next = busy_count_next + {{IDX_W{1'b0}}, table_next[i].busy};
        end
        full_next     = (busy_count_next == (IDX_W + 1)'(NUM_UIDS));
        err_free_next = err_free_reg || (free_valid && !free_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            unique_id_reg  <= '0;
            busy_count_reg <= '0;
            full_reg       <= 1'b0;
            err_free_reg   <= 1'b0;
            for (int i = 0; i < NUM_UIDS; i++) begin
                table_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            unique_id_reg  <= unique_id_next;
            busy_count_reg <= busy_count_next;
            full_reg       <= full_next;
            err_free_reg   <= err_free_next;
            for (int i = 0; i < NUM_UIDS; i++) begin
                table_reg[i] <= table_next[i];
            end
        end
    end

    assign alloc_gnt  = (state_reg == GRANT);
    assign unique_id  = unique_id_reg;
    assign busy_count = busy_count_reg;
    assign full       = full_reg;
    assign err_free   = err_free_reg;

endmodule

// File: tb/tb_ar_uid_allocator.sv
// Self-checking bench for ar_uid_allocator: table-driven fill plus scoreboarded
// grants and hand-written sequences for stalls, frees and reset.
module tb_ar_uid_allocator;

    localparam int ID_W  = 5;
    localparam int UID_W = 8;
    localparam int NUM   = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             alloc_req = 1'b0;
    logic [ID_W-1:0]  alloc_in_id = '0;
    logic             alloc_gnt;
    logic [UID_W-1:0] unique_id;
    logic [UID_W-1:0] lookup_uid = '0;
    logic [ID_W-1:0]  lookup_id;
    logic             lookup_hit;
    logic             free_valid = 1'b0;
    logic [UID_W-1:0] free_uid = '0;
    logic [4:0]       busy_count;
    logic             full;
    logic             err_free;

    ar_uid_allocator #(
        .ID_WIDTH(ID_W), .UID_WIDTH(UID_W), .NUM_UIDS(NUM), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_in_id(alloc_in_id),
        .alloc_gnt(alloc_gnt), .unique_id(unique_id),
        .lookup_uid(lookup_uid), .lookup_id(lookup_id), .lookup_hit(lookup_hit),
        .free_valid(free_valid), .free_uid(free_uid),
        .busy_count(busy_count), .full(full), .err_free(err_free)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int uid;
        int busy;
        int full;
    } vec_t;

    vec_t vecs[NUM];
    int   nvec = 0;
    int   nerr = 0;
    int   exp_q[$];
    int   last_exp = 0;
    int   lat;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_req(input int id, input int uid);
        alloc_req   = 1'b1;
        alloc_in_id = ID_W'(id);
        exp_q.push_back(uid);
    endtask

    task automatic expect_grant(output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!alloc_gnt && l < 50);
        if (!alloc_gnt) begin
            check("grant_timeout", 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            last_exp = exp_q.pop_front();
            check("unique_id", int'(unique_id), last_exp);
            $display("grant id=%0d uid=%0d latency=%0d", alloc_in_id, unique_id, l);
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        check("gnt_hold", int'(alloc_gnt), 1);
        check("uid_stable", int'(unique_id), last_exp);
        alloc_req = 1'b0;
        @(negedge clk);
        check("gnt_drop", int'(alloc_gnt), 0);
    endtask

    task automatic do_alloc(input int id, input int uid);
        int l;
        start_req(id, uid);
        expect_grant(l);
        release_req();
    endtask

    task automatic do_free(input int uid);
        free_valid = 1'b1;
        free_uid   = UID_W'(uid);
        @(negedge clk);
        free_valid = 1'b0;
        $display("free uid=%0d busy_count=%0d err_free=%0d", uid, busy_count, err_free);
    endtask

    task automatic stall_check(input int n);
        repeat (n) begin
            @(negedge clk);
            check("stall_no_gnt", int'(alloc_gnt), 0);
        end
    endtask

    task automatic check_lookup(input int uid, input int exp_hit, input int exp_id);
        lookup_uid = UID_W'(uid);
        #1;
        check("lookup_hit", int'(lookup_hit), exp_hit);
        if (exp_hit != 0) check("lookup_id", int'(lookup_id), exp_id);
    endtask

    initial begin
        for (int i = 0; i < NUM; i++) begin
            vecs[i].id   = i;
            vecs[i].uid  = i;
            vecs[i].busy = i + 1;
            vecs[i].full = (i == NUM - 1) ? 1 : 0;
        end

        // Reset state
        #1;
        check("rst_gnt", int'(alloc_gnt), 0);
        check("rst_uid", int'(unique_id), 0);
        check("rst_busy", int'(busy_count), 0);
        check("rst_full", int'(full), 0);
        check("rst_err", int'(err_free), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First grant and its latency
        start_req(3, 0);
        expect_grant(lat);
        check("grant_latency", lat, 1);
        release_req();
        check("busy_after_first", int'(busy_count), 1);
        check_lookup(0, 1, 3);

        // Same ID shares a UID; a new ID takes the next idle entry
        do_alloc(3, 0);
        do_alloc(5, 1);
        check("busy_two", int'(busy_count), 2);
        do_free(0);
        check_lookup(0, 1, 3);
        do_free(0);
        check_lookup(0, 0, 0);
        check("busy_after_free", int'(busy_count), 1);
        do_free(1);
        check("busy_empty", int'(busy_count), 0);
        check("err_clean", int'(err_free), 0);

        // Fill the table from the vector table
        for (int i = 0; i < NUM; i++) begin
            do_alloc(vecs[i].id, vecs[i].uid);
            check("fill_busy", int'(busy_count), vecs[i].busy);
            check("fill_full", int'(full), vecs[i].full);
        end
        check_lookup(5, 1, 5);
        check_lookup(20, 0, 0);

        // Full table still serves a matching ID
        do_alloc(7, 7);
        check("full_match_busy", int'(busy_count), NUM);

        // New ID stalls until an entry is freed
        start_req(20, 2);
        stall_check(3);
        do_free(2);
        expect_grant(lat);
        release_req();
        check_lookup(2, 1, 20);
        check("refill_full", int'(full), 1);

        for (int i = 0; i < NUM; i++) do_free(i);
        do_free(7);
        check("drain_busy", int'(busy_count), 0);
        check("drain_full", int'(full), 0);
        check("drain_err", int'(err_free), 0);

        // Counter saturation on a single ID
        for (int k = 0; k < 15; k++) do_alloc(9, 0);
        check("sat_busy", int'(busy_count), 1);
        start_req(9, 0);
        stall_check(3);
        do_free(0);
        expect_grant(lat);
        release_req();
        check_lookup(0, 1, 9);
        for (int k = 0; k < 14; k++) do_free(0);
        check_lookup(0, 1, 9);
        do_free(0);
        check_lookup(0, 0, 0);
        check("sat_drain_busy", int'(busy_count), 0);

        // Free of an idle UID
        do_alloc(4, 0);
        do_free(9);
        check("err_idle_free", int'(err_free), 1);
        check("err_busy_kept", int'(busy_count), 1);
        @(negedge clk);
        check("err_sticky", int'(err_free), 1);

        // Free and match search in the same cycle
        start_req(4, 0);
        free_valid = 1'b1;
        free_uid   = '0;
        @(negedge clk);
        free_valid = 1'b0;
        expect_grant(lat);
        release_req();
        check("same_cycle_busy", int'(busy_count), 1);
        check_lookup(0, 1, 4);
        do_free(0);
        check_lookup(0, 0, 0);
        check("same_cycle_drain", int'(busy_count), 0);

        // Reset in the middle of a grant
        do_alloc(8, 0);
        start_req(6, 1);
        expect_grant(lat);
        lookup_uid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_gnt", int'(alloc_gnt), 0);
        check("rst_mid_busy", int'(busy_count), 0);
        check("rst_mid_err", int'(err_free), 0);
        check("rst_mid_hit", int'(lookup_hit), 0);
        alloc_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Out-of-range free after reset
        do_free(20);
        check("err_range_free", int'(err_free), 1);
        check("err_range_busy", int'(busy_count), 0);
        do_alloc(6, 0);
        check("post_rst_busy", int'(busy_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ar_uid_allocator.md
Name: ar_uid_allocator

Overview:
- Tag allocator serving the AR ID-remapping stage. It maps each master ARID to an internal UID and hands the UID back on the alloc handshake.
- Keeps a UID table (busy, original ID, outstanding count) so the R-return path can translate a UID back to its ARID and release it on RLAST.
- Same-ARID requests always map to the same live UID, which preserves AXI same-ID read ordering at the slave.

Parameters:
- ID_WIDTH, 4, width of master ARID.
- UID_WIDTH, 8, width of unique_id; upper bits above clog2(NUM_UIDS) are driven 0.
- NUM_UIDS, 16, table entries; legal range 2..2**UID_WIDTH.
- CNT_WIDTH, 4, per-entry outstanding counter width; saturation value is 2**CNT_WIDTH-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req  in  1  level request from the AR stage; held until its m_ar handshake completes.
- alloc_in_id  in  ID_WIDTH  original ARID; stable while alloc_req is high.
- alloc_gnt  out  1  UID valid; held high while alloc_req stays high.
- unique_id  out  UID_WIDTH  granted UID; stable while alloc_gnt is high.
- lookup_uid  in  UID_WIDTH  UID from the R channel.
- lookup_id  out  ID_WIDTH  original ARID of lookup_uid; combinational.
- lookup_hit  out  1  lookup_uid < NUM_UIDS and that entry is busy.
- free_valid  in  1  one-cycle release pulse (R handshake with RLAST); always accepted.
- free_uid  in  UID_WIDTH  UID to release.
- busy_count  out  clog2(NUM_UIDS)+1  number of busy entries.
- full  out  1  busy_count == NUM_UIDS.
- err_free  out  1  sticky flag: a free targeted an idle or out-of-range UID.

Behaviour:
- Reset (async assert, sync release): all entries idle with cnt=0. Outputs reset to alloc_gnt=0, unique_id=0, busy_count=0, full=0, err_free=0. FSM goes to IDLE.
- A grant in progress when reset asserts is abandoned. The requester sees alloc_gnt fall.
- FSM has two states, IDLE and GRANT.
- IDLE, alloc_req=1: search the registered table state from the current cycle.
  - Match: a busy entry with orig_id==alloc_in_id.
  - Match with cnt < max: select it and increment cnt.
  - Match with cnt saturated: stall. Do not open a second entry for the same ID.
  - No match, free entry exists: select the lowest-index idle entry, set busy=1, orig_id=alloc_in_id, cnt=1.
  - No match, no free entry: stall and retry every cycle.
  - On a successful selection, register unique_id and go to GRANT.
- Grant latency: alloc_req seen in cycle N means alloc_gnt=1 in cycle N+1 at the earliest.
- GRANT: alloc_gnt=1 and unique_id held. When alloc_req falls, the grant was consumed: drop alloc_gnt the next cycle and return to IDLE.
  - A new alloc_req is only evaluated from IDLE, so there is no back-to-back grant without an IDLE cycle.
- Table commit happens at the IDLE→GRANT transition. It is never rolled back.
- Free (free_valid=1), in range and busy: decrement cnt. When cnt reaches 0, clear busy; orig_id is don't-care.
- Free of an idle or out-of-range UID: table unchanged, err_free set to 1 until reset.
- Simultaneous increment and free on the same entry: net cnt unchanged and busy stays 1.
- A free in the same cycle as a search is not visible to that search. This is conservative: the search may stall one extra cycle.
- busy_count and full are registered and track the table every cycle.

Decomposition:
- Package ar_uid_pkg holds:
  - entry_t struct: busy, orig_id, cnt.
  - FSM state enum: IDLE, GRANT.
  - Helper function returning clog2-based index width.
- Sub-module uid_prio_enc: parameterised lowest-set-bit priority encoder, outputs found flag and index. Instantiate it twice, once for the ID-match vector and once for the idle-entry vector.

Test Plan:
- Reset then alloc_req=1 with id=3 → alloc_gnt=1 in cycle 2, unique_id=0, busy_count=1. Drop alloc_req → gnt falls next cycle; lookup_uid=0 gives lookup_id=3, lookup_hit=1.
- Two grants with id=3 then one with id=5 → UIDs 0, 0, 1; entry 0 cnt=2. Free UID 0 once → still hit. Free again → lookup_hit=0, busy_count=1.
- NUM_UIDS=16: allocate ids 0..15 (all distinct) → full=1. Request id=7 → gnt (matches entry 7). Request new id with table full → stalls with no gnt; free UID 2 (cnt 1) → next request is granted UID 2.
- Same id granted 15 times (CNT_WIDTH=4) → 16th request stalls. One free → grant resumes with the same UID.
- Free UID 9 while idle, or free UID 20 → err_free=1 sticky; busy_count unchanged.
- Free of entry 0 (cnt=1) in the same cycle a match search for the same id starts → search uses the pre-free table: grant with UID 0, cnt ends at 1, busy stays 1.
- Assert rst_n=0 during GRANT → alloc_gnt=0 immediately, all entries idle, err_free=0.
